// File: rtl/apb_mst_pkg.sv
// Shared types for the APB master bridge: FSM state, captured response, default watchdog depth.
// The watchdog default only matters when APB_MST_TIMEOUT_EN is defined.
package apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // APB4 data is at most 32 bits wide, so the response container is sized for that.
    localparam int unsigned RDATA_W_MAX = 32;

    typedef struct packed {
        logic [RDATA_W_MAX-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } rsp_t;

`ifdef APB_MST_TIMEOUT_EN
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
`else
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2;
`endif

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response stream plus APB4 requester signals for apb_master_bridge.
// master = bridge side, slave = command source / response sink / APB completer side.
interface apb_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strb;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_mst_wdog.sv
// ACCESS-phase wait counter; expire_o flags the last permitted wait cycle.
// Only instantiated when APB_MST_TIMEOUT_EN is defined.
module apb_mst_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = (cnt_q == LAST);

    // Saturate at LAST so the counter never wraps if the FSM lingers.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && !expire_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: valid/ready command in, SETUP/ACCESS transfer, response out.
// Optional ACCESS watchdog enabled by defining APB_MST_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high, PENABLE low
// ACCESS | PSEL/PENABLE high, waiting for PREADY (or watchdog)
// RESP   | rsp_valid high, holding response until rsp_ready
module apb_master_bridge
    import apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_master_bridge_if.master bus
);

    state_e                  state_q;
    logic                    cmd_ready_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    rsp_valid_q;
    rsp_t                    rsp_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [DATA_WIDTH/8-1:0] pstrb_q;
    logic                    wd_expire;

`ifdef APB_MST_TIMEOUT_EN
    apb_mst_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (PCLK),
        .rst_i    (PRESET),
        .clear_i  (state_q == SETUP),
        .inc_i    ((state_q == ACCESS) && !bus.PREADY),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        pwrite_q    <= bus.cmd_write;
                        paddr_q     <= bus.cmd_addr;
                        pwdata_q    <= bus.cmd_wdata;
                        pstrb_q     <= bus.cmd_write ? bus.cmd_strb : '0;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over an expiring watchdog in the same cycle.
                    if (bus.PREADY) begin
                        rsp_q.rdata   <= pwrite_q ? '0 : RDATA_W_MAX'(bus.PRDATA);
                        rsp_q.err     <= bus.PSLVERR;
                        rsp_q.timeout <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (wd_expire) begin
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_q.rdata[DATA_WIDTH-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed cases plus randomized traffic against a memory model.
// Timeout cases are exercised when APB_MST_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

`ifdef APB_MST_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1 << 30;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
        int          len;
    } exp_t;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } bus_t;

    logic PCLK;
    logic PRESET;
    int   cyc;
    int   total;
    int   bad;

    apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_master_bridge #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    int          wait_q[$];
    logic [31:0] mmem[256];
    logic [31:0] smem[256];
    int          acc_cyc;
    bit          rsp_hold;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic bit is_err(logic [7:0] a);
        return a[7:4] == 4'h3;
    endfunction

    // Reference: outcome of one command given its wait-state count.
    function automatic exp_t model(bit w, logic [7:0] a, logic [3:0] s, logic [31:0] d, int waits);
        exp_t e;
        if (waits >= TMO) begin
            e.len = TMO; e.err = 1'b1; e.tmo = 1'b1; e.rdata = 32'h0;
        end else begin
            e.len = waits + 1; e.err = is_err(a); e.tmo = 1'b0;
            e.rdata = w ? 32'h0 : mmem[a];
            if (w && !e.err)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mmem[a][8*b +: 8] = d[8*b +: 8];
        end
        return e;
    endfunction

    // APB completer: wait states per transfer from wait_q, junk on PRDATA/PSLVERR while not ready.
    int wait_left;
    always @(negedge PCLK) begin
        if (PRESET) begin
            wait_left = 0;
            bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h0;
        end else if (bus.PSEL && !bus.PENABLE) begin
            wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
        end else if (bus.PSEL && bus.PENABLE) begin
            if (wait_left > 0) begin
                wait_left--;
                bus.PREADY = 1'b0; bus.PSLVERR = 1'b1; bus.PRDATA = $urandom;
            end else begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = is_err(bus.PADDR);
                bus.PRDATA  = bus.PWRITE ? $urandom : smem[bus.PADDR];
                if (bus.PWRITE && !is_err(bus.PADDR))
                    for (int b = 0; b < 4; b++)
                        if (bus.PSTRB[b]) smem[bus.PADDR][8*b +: 8] = bus.PWDATA[8*b +: 8];
            end
        end else begin
            bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
        end
    end

    always @(posedge PCLK) begin
        #1;
        bus.rsp_ready = rsp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: bus protocol, latency and scoreboard compare on rsp_valid.
    bus_t        cur_bus;
    exp_t        cur_exp;
    int          setup_cyc, acc_len, exp_setup;
    bit          exp_setup_v, prev_rv;
    logic [33:0] saved_rsp;
    always @(negedge PCLK) begin
        if (PRESET) begin
            exp_setup_v = 1'b0; prev_rv = 1'b0; acc_len = 0;
        end else begin
            if (bus.PSEL && !bus.PENABLE) begin
                if (bus_q.size() == 0) chk("unexpected_setup", 64'd1, 64'd0);
                else cur_bus = bus_q.pop_front();
                chk("setup_latency", 64'(cyc), 64'(acc_cyc + 1));
                if (exp_setup_v) chk("setup_after_rsp", 64'(cyc), 64'(exp_setup));
                exp_setup_v = 1'b0;
                setup_cyc = cyc; acc_len = 0;
                chk("setup_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
                    {cur_bus.w, cur_bus.a, cur_bus.d, cur_bus.s});
            end
            if (bus.PSEL && bus.PENABLE) begin
                acc_len++;
                chk("access_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA, bus.PSTRB},
                    {cur_bus.w, cur_bus.a, cur_bus.d, cur_bus.s});
            end
            if (bus.rsp_valid) begin
                chk("resp_idle_bus", {bus.cmd_ready, bus.PSEL, bus.PENABLE}, 64'd0);
                if (!prev_rv) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        cur_exp = exp_q.pop_front();
                        chk("rsp_data", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout},
                            {cur_exp.rdata, cur_exp.err, cur_exp.tmo});
                        chk("access_len", 64'(acc_len), 64'(cur_exp.len));
                        chk("rsp_latency", 64'(cyc), 64'(setup_cyc + acc_len + 1));
                    end
                end else begin
                    chk("rsp_stable", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, saved_rsp);
                end
                saved_rsp = {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
                if (bus.rsp_ready && bus.cmd_valid) begin
                    exp_setup = cyc + 2; exp_setup_v = 1'b1;
                end
            end
            prev_rv = bus.rsp_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_cmd(bit w, logic [7:0] a, logic [31:0] d, logic [3:0] s, int waits);
        int n;
        exp_q.push_back(model(w, a, s, d, waits));
        bus_q.push_back('{w, a, d, w ? s : 4'h0});
        wait_q.push_back(waits);
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a;
        bus.cmd_wdata = d; bus.cmd_strb = s;
        n = 0;
        while (n < 300) begin
            @(negedge PCLK);
            if (bus.cmd_ready) break;
            n++;
        end
        if (n >= 300) chk("cmd_accept_timeout", 64'd1, 64'd0);
        acc_cyc = cyc;
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(string name);
        chk({name, "_ctl"}, {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout,
                             bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PSTRB}, 64'd0);
        chk({name, "_data"}, {bus.PADDR, bus.PWDATA}, 64'd0);
        chk({name, "_rdata"}, 64'(bus.rsp_rdata), 64'd0);
    endtask

    initial begin
        #800000;
        $display("FAIL global_time_limit actual=expired required=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int n;
        total = 0; bad = 0; rsp_hold = 1'b0; acc_cyc = 0;
        PRESET = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_strb = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mmem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
            smem[i] = mmem[i];
        end
        mmem[8'h24] = 32'h1234_5678;
        smem[8'h24] = 32'h1234_5678;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk_all_zero("reset");
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("cmd_ready_reset_cycle", 64'(bus.cmd_ready), 64'd0);
        @(negedge PCLK);
        chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        @(posedge PCLK); #1;

        do_cmd(1'b1, 8'h10, 32'hDEAD_BEEF, 4'hF, 0);
        do_cmd(1'b0, 8'h24, 32'h0BAD_F00D, 4'hA, 3);
        do_cmd(1'b1, 8'h30, 32'h5555_AAAA, 4'h3, 2);
        do_cmd(1'b0, 8'h10, 32'h0, 4'h0, 1);

        // Response backpressure with a second command waiting.
        rsp_hold = 1'b1;
        fork
            begin
                do_cmd(1'b0, 8'h44, 32'h1, 4'h1, 0);
                do_cmd(1'b1, 8'h48, 32'hCAFE_F00D, 4'hC, 1);
            end
            begin
                repeat (12) @(posedge PCLK);
                @(negedge PCLK);
                rsp_hold = 1'b0;
            end
        join

`ifdef APB_MST_TIMEOUT_EN
        do_cmd(1'b1, 8'h50, 32'h1111_2222, 4'hF, 100);
        do_cmd(1'b0, 8'h50, 32'h0, 4'h0, 15);
        do_cmd(1'b0, 8'h54, 32'h0, 4'h0, 16);
`endif

        // Reset while ACCESS is waiting on the slave; no response may appear.
        wait_q.push_back(6);
        bus_q.push_back('{1'b0, 8'h60, 32'h7, 4'h0});
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h60;
        bus.cmd_wdata = 32'h7; bus.cmd_strb = 4'hF;
        n = 0;
        while (n < 300) begin
            @(negedge PCLK);
            if (bus.cmd_ready) break;
            n++;
        end
        acc_cyc = cyc;
        @(posedge PCLK); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge PCLK);
            if (bus.PSEL && bus.PENABLE) break;
            n++;
        end
        if (n >= 50) chk("reach_access_timeout", 64'd1, 64'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk_all_zero("mid_reset");
        @(negedge PCLK);
        chk("cmd_ready_after_mid_reset", 64'(bus.cmd_ready), 64'd1);
        @(posedge PCLK); #1;
        do_cmd(1'b0, 8'h24, 32'h0, 4'h0, 1);

        for (int i = 0; i < 200; i++) begin
            do_cmd(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4));
        end

        n = 0;
        while (n < 500 && (exp_q.size() != 0 || bus.rsp_valid)) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB4 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers. It drives the APB slave's PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB and returns read data or error on a valid/ready response channel. It sits directly upstream of the APB slave, on the same PCLK domain.

## Interface
- ADDR_WIDTH, 8, PADDR and cmd_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; must be a multiple of 8
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; only used with APB_MST_TIMEOUT_EN; must be ≥ 2
- PCLK  input  1  clock; all logic on its rising edge
- PRESET  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- cmd_strb  input  DATA_WIDTH/8  write byte strobes
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
- rsp_err  output  1  PSLVERR captured, or timeout
- rsp_timeout  output  1  transfer aborted by watchdog; tied 0 without APB_MST_TIMEOUT_EN
- PSEL  output  1  slave select
- PENABLE  output  1  access phase
- PWRITE  output  1  direction
- PADDR  output  ADDR_WIDTH  address
- PWDATA  output  DATA_WIDTH  write data
- PSTRB  output  DATA_WIDTH/8  byte strobes; all 0 on reads
- PRDATA  input  DATA_WIDTH  slave read data
- PREADY  input  1  slave ready
- PSLVERR  input  1  slave error; valid only when PREADY = 1

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - cmd_ready = 1.
  - On handshake: latch write/addr/wdata/strb into PWRITE/PADDR/PWDATA/PSTRB (PSTRB forced to 0 if read), then go to SETUP.
- **SETUP**
  - PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - PSEL = 1, PENABLE = 1.
  - If PREADY = 1: capture rsp_rdata = PRDATA (read) or 0 (write), and rsp_err = PSLVERR. Then go to RESP.
  - Otherwise stay in ACCESS.
- **RESP**
  - PSEL = PENABLE = 0, rsp_valid = 1.
  - rsp_* held stable until rsp_ready = 1, then go to IDLE.
- cmd_ready is 0 in every state except IDLE; at most one transfer is outstanding.
- PADDR/PWRITE/PWDATA/PSTRB stay stable from SETUP through the end of ACCESS and keep their values in RESP and IDLE; they change only at command acceptance.
- PRDATA and PSLVERR are ignored whenever PREADY = 0 or PENABLE = 0.
- **Reset values:** all outputs 0 (cmd_ready 0 while PRESET = 1, 1 on the first cycle after); FSM = IDLE.
- **Reset mid-transfer:** the next edge forces reset values. No response is ever produced for the aborted command.

## Timing
- Command accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With zero-wait PREADY, rsp_valid rises in cycle 3.
- Each PREADY = 0 cycle in ACCESS adds one cycle.
- With rsp_ready held high, back-to-back throughput is one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP).
- rsp_valid falls on the edge following the rsp handshake; cmd_ready rises in that same cycle.
- No combinational path from any input to any output.

## Configuration
- **APB_MST_TIMEOUT_EN defined:**
  - The wait counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - If PREADY = 0 in the cycle where the counter equals TIMEOUT_CYCLES-1, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0. ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - PREADY = 1 in that same final cycle completes normally; it takes priority over the timeout.
- **APB_MST_TIMEOUT_EN undefined:** no counter is built, rsp_timeout = 0, and ACCESS waits indefinitely.

## Structure
- **Shared package apb_mst_pkg:**
  - state enum (IDLE/SETUP/ACCESS/RESP)
  - response struct {rdata, err, timeout}
  - APB_MST_TIMEOUT_EN-gated default for TIMEOUT_CYCLES
- **Sub-module apb_mst_wdog:** wait counter of width $clog2(TIMEOUT_CYCLES), with clear/inc inputs and an expire output. Instantiated only under APB_MST_TIMEOUT_EN.

## Test plan
- **Zero-wait write:** write addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY always 1 → PSEL in cycle 1, PENABLE in cycle 2, rsp_valid in cycle 3, rsp_err 0, rsp_rdata 0.
- **Read with 3 wait states:** read addr 0x24, PRDATA 0x12345678, PREADY low 3 cycles → ACCESS lasts 4 cycles, rsp_rdata 0x12345678, PSTRB 0 throughout, PADDR stable.
- **Slave error:** write addr 0x30; PSLVERR = 1 with PREADY = 1 → rsp_err 1. Also drive PSLVERR = 1 while PREADY = 0 in an earlier cycle → ignored.
- **Response backpressure:** rsp_ready held low 5 cycles → rsp_* stable, cmd_ready 0, a pending cmd_valid is not accepted; after release the next command reaches SETUP 2 cycles after the rsp handshake.
- **Timeout (macro on, TIMEOUT_CYCLES 16):** PREADY held 0 → exactly 16 ACCESS cycles, then rsp_err = rsp_timeout = 1. Repeat with PREADY = 1 on the 16th cycle → normal completion, rsp_timeout 0.
- **Mid-transfer reset:** assert PRESET for one cycle during ACCESS → next cycle all outputs 0, FSM IDLE, no rsp_valid; the following command completes normally.
